alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: types shared by the ALU issue controller and its command FIFO.
//   ALU_W     - operand/result width of the team's combinational ALU
//   alu_op_e  - 3-bit ALU opcode encoding
//   alu_cmd_t - one queued command {op, a, b, use_acc}
//   state_e   - issue FSM states
package alu_pkg;

  localparam int ALU_W = 12;

  typedef enum logic [2:0] {
    OP_ABS = 3'd0,
    OP_SHL = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_ADD = 3'd6,
    OP_SUB = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             use_acc;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO storing alu_cmd_t.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   push, din      - write request and command (ignored when full)
//   pop, dout      - read request (ignored when empty) and head command
//   full, empty    - status derived from registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_cmd_t din,
  input  logic     pop,
  output alu_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issue/retire stage around the combinational ALU.
// Ports:
//   cmd_valid/cmd_ready, cmd_op/cmd_a/cmd_b/cmd_use_acc - command input handshake
//   alu_a/alu_b/alu_op                                   - registered ALU operands
//   alu_z/alu_carry/alu_sign/alu_ov                      - ALU result and flags
//   res_valid/res_ready, res_z/res_carry/res_sign/res_ov - registered result handshake
//   busy                                                 - FSM not IDLE or FIFO not empty
// Optional macro STICKY_FLAGS_EN adds flag_clr, sticky_ov and sticky_carry.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_z,
  input  logic         alu_carry,
  input  logic         alu_sign,
  input  logic         alu_ov,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_z,
  output logic         res_carry,
  output logic         res_sign,
  output logic         res_ov,
  output logic         busy
`ifdef STICKY_FLAGS_EN
  ,
  input  logic         flag_clr,
  output logic         sticky_ov,
  output logic         sticky_carry
`endif
);

  state_e       state;
  logic [W-1:0] acc;
  alu_cmd_t     wr_cmd;
  alu_cmd_t     head;
  logic         full;
  logic         empty;
  logic         pop;

  assign wr_cmd.op      = alu_op_e'(cmd_op);
  assign wr_cmd.a       = cmd_a;
  assign wr_cmd.b       = cmd_b;
  assign wr_cmd.use_acc = cmd_use_acc;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (wr_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign busy      = (state != IDLE) || !empty;
  assign pop       = !empty && ((state == IDLE) || ((state == HOLD) && res_ready));

  // acc is written on the EXEC->HOLD edge, so any pop from HOLD already
  // sees the result of the immediately preceding command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_z     <= '0;
      res_carry <= 1'b0;
      res_sign  <= 1'b0;
      res_ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a  <= head.use_acc ? acc : head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_z     <= alu_z;
          res_carry <= alu_carry;
          res_sign  <= alu_sign;
          res_ov    <= alu_ov;
          res_valid <= 1'b1;
          acc       <= alu_z;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_a  <= head.use_acc ? acc : head.a;
              alu_b  <= head.b;
              alu_op <= head.op;
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STICKY_FLAGS_EN
  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ov    <= 1'b0;
      sticky_carry <= 1'b0;
    end else begin
      if ((state == EXEC) && alu_ov) sticky_ov <= 1'b1;
      else if (flag_clr)             sticky_ov <= 1'b0;
      if ((state == EXEC) && alu_carry) sticky_carry <= 1'b1;
      else if (flag_clr)                sticky_carry <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl.
// A behavioural 12-bit ALU closes the loop from alu_a/alu_b/alu_op back to
// alu_z and the flags. Inputs change 2 time units after the rising edge;
// completed result handshakes are logged on the falling edge.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_z;
  logic         alu_carry;
  logic         alu_sign;
  logic         alu_ov;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_z;
  logic         res_carry;
  logic         res_sign;
  logic         res_ov;
  logic         busy;
`ifdef STICKY_FLAGS_EN
  logic         flag_clr;
  logic         sticky_ov;
  logic         sticky_carry;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .W     (W),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_z       (alu_z),
    .alu_carry   (alu_carry),
    .alu_sign    (alu_sign),
    .alu_ov      (alu_ov),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_z       (res_z),
    .res_carry   (res_carry),
    .res_sign    (res_sign),
    .res_ov      (res_ov),
    .busy        (busy)
`ifdef STICKY_FLAGS_EN
    ,
    .flag_clr     (flag_clr),
    .sticky_ov    (sticky_ov),
    .sticky_carry (sticky_carry)
`endif
  );

  // Behavioural ALU
  logic [W:0] ext;
  always_comb begin
    ext       = '0;
    alu_z     = '0;
    alu_carry = 1'b0;
    alu_ov    = 1'b0;
    case (alu_op)
      3'd0: alu_z = alu_a[W-1] ? (~alu_a + 1'b1) : alu_a;
      3'd1: alu_z = {alu_b[W-2:0], 1'b0};
      3'd2: alu_z = alu_a & alu_b;
      3'd3: alu_z = alu_a | alu_b;
      3'd4: alu_z = alu_a ^ alu_b;
      3'd5: alu_z = ~alu_a;
      3'd6: begin
        ext       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_z     = ext[W-1:0];
        alu_carry = ext[W];
        alu_ov    = (alu_a[W-1] == alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
      end
      default: begin
        ext       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_z     = ext[W-1:0];
        alu_carry = ext[W];
        alu_ov    = (alu_a[W-1] != alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
      end
    endcase
    alu_sign = alu_z[W-1];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result log: a handshake seen mid-cycle completes at the next edge.
  logic [W-1:0] q_z [$];
  logic         q_ov [$];
  int           q_cyc [$];

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      q_z.push_back(res_z);
      q_ov.push_back(res_ov);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log;
    q_z.delete();
    q_ov.delete();
    q_cyc.delete();
  endtask

  function automatic logic [31:0] log_z(input int i);
    return (q_z.size() > i) ? 32'(q_z[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] log_ov(input int i);
    return (q_ov.size() > i) ? 32'(q_ov[i]) : 32'hDEAD;
  endfunction

  function automatic int log_cyc(input int i);
    return (q_cyc.size() > i) ? q_cyc[i] : -1000;
  endfunction

  task automatic push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ua);
    int n;
    n           = 0;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    while (!cmd_ready && n < 20) begin
      tick;
      n++;
    end
    if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy || res_valid) && n < 50) begin
      tick;
      n++;
    end
    chk("idle_timeout", 32'(busy | res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
    res_ready   = 1'b1;
`ifdef STICKY_FLAGS_EN
    flag_clr    = 1'b0;
`endif
    tick;
    tick;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_res_z", 32'(res_z), 32'd0);
    rst_n = 1'b1;
    tick;

    // ADD overflow, latency N+1 pop, N+2 result
    push(3'd6, 12'h7FF, 12'h001, 1'b0);
    chk("add_n_valid", 32'(res_valid), 32'd0);
    chk("add_n_busy", 32'(busy), 32'd1);
    tick;
    chk("add_n1_valid", 32'(res_valid), 32'd0);
    chk("add_n1_alu_a", 32'(alu_a), 32'h7FF);
    chk("add_n1_alu_b", 32'(alu_b), 32'h001);
    chk("add_n1_alu_op", 32'(alu_op), 32'd6);
    tick;
    chk("add_n2_valid", 32'(res_valid), 32'd1);
    chk("add_z", 32'(res_z), 32'h800);
    chk("add_sign", 32'(res_sign), 32'd1);
    chk("add_ov", 32'(res_ov), 32'd1);
    chk("add_carry", 32'(res_carry), 32'd0);
    tick;
    chk("add_done_valid", 32'(res_valid), 32'd0);
    chk("add_done_busy", 32'(busy), 32'd0);
    tick;
    chk("idle_alu_a_hold", 32'(alu_a), 32'h7FF);

    // Accumulator chaining
    clear_log;
    push(3'd7, 12'h005, 12'h003, 1'b0);
    push(3'd6, 12'hABC, 12'h010, 1'b1);
    wait_idle;
    chk("chain_count", 32'(q_z.size()), 32'd2);
    chk("chain_z0", log_z(0), 32'h002);
    chk("chain_z1", log_z(1), 32'h012);

    // AND then NOT
    clear_log;
    push(3'd2, 12'hF0F, 12'h0FF, 1'b0);
    push(3'd5, 12'h000, 12'h000, 1'b0);
    wait_idle;
    chk("logic_z0", log_z(0), 32'h00F);
    chk("logic_ov0", log_ov(0), 32'd0);
    chk("logic_z1", log_z(1), 32'hFFF);
    chk("logic_ov1", log_ov(1), 32'd0);

    // Back-pressure: one in HOLD plus two queued
    clear_log;
    res_ready = 1'b0;
    push(3'd4, 12'h00F, 12'h0F0, 1'b0);
    push(3'd3, 12'h100, 12'h001, 1'b0);
    push(3'd1, 12'h000, 12'h123, 1'b0);
    chk("bp_valid", 32'(res_valid), 32'd1);
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_z", 32'(res_z), 32'h0FF);
    tick;
    tick;
    tick;
    chk("bp_z_stable", 32'(res_z), 32'h0FF);
    chk("bp_valid_stable", 32'(res_valid), 32'd1);
    chk("bp_ready_still_low", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    wait_idle;
    chk("bp_count", 32'(q_z.size()), 32'd3);
    chk("bp_z0", log_z(0), 32'h0FF);
    chk("bp_z1", log_z(1), 32'h101);
    chk("bp_z2", log_z(2), 32'h246);
    chk("bp_gap01", 32'(log_cyc(1) - log_cyc(0)), 32'd2);
    chk("bp_gap12", 32'(log_cyc(2) - log_cyc(1)), 32'd2);

    // Reset during HOLD with two queued
    res_ready = 1'b0;
    push(3'd4, 12'h00F, 12'h0F0, 1'b0);
    push(3'd3, 12'h100, 12'h001, 1'b0);
    push(3'd1, 12'h000, 12'h123, 1'b0);
    chk("mr_pre_ready", 32'(cmd_ready), 32'd0);
    chk("mr_pre_valid", 32'(res_valid), 32'd1);
    clear_log;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(res_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    tick;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (6) tick;
    chk("mr_no_results", 32'(q_z.size()), 32'd0);
    chk("mr_busy_after", 32'(busy), 32'd0);
    chk("mr_res_z", 32'(res_z), 32'd0);

`ifdef STICKY_FLAGS_EN
    chk("st_rst_ov", 32'(sticky_ov), 32'd0);
    push(3'd6, 12'h7FF, 12'h001, 1'b0);
    wait_idle;
    chk("st_ov_set", 32'(sticky_ov), 32'd1);
    push(3'd2, 12'hF0F, 12'h0FF, 1'b0);
    wait_idle;
    chk("st_ov_kept", 32'(sticky_ov), 32'd1);
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk("st_ov_clr", 32'(sticky_ov), 32'd0);
    push(3'd6, 12'h7FF, 12'h001, 1'b0);
    tick;
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk("st_set_wins", 32'(sticky_ov), 32'd1);
    wait_idle;
    chk("st_carry_zero", 32'(sticky_carry), 32'd0);
    push(3'd6, 12'hFFF, 12'h001, 1'b0);
    wait_idle;
    chk("st_carry_set", 32'(sticky_carry), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
